// File: rtl/led_pkg.sv
// Shared constants for the LED line packer and the LED SPI controller.
package led_pkg;

  localparam int LED_BYTE_W          = 8;
  localparam int LED_BYTES_PER_LINE  = 50;
  localparam int LED_LINE_W          = LED_BYTE_W * LED_BYTES_PER_LINE;
  localparam int LED_LINES_PER_FRAME = 256;
  localparam int LED_IDX_W           = $clog2(LED_LINES_PER_FRAME);

  // Counter width that stays legal even for a one-entry range.
  function automatic int led_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_line_bank.sv
// One half of the ping-pong line buffer: line storage with byte-lane writes,
// the full flag and the line index latched when the line completes.
import led_pkg::*;

module led_line_bank #(
  parameter int  BYTE_W         = LED_BYTE_W,
  parameter int  BYTES_PER_LINE = LED_BYTES_PER_LINE,
  parameter int  IDX_W          = LED_IDX_W,
  localparam int LINE_W         = BYTE_W * BYTES_PER_LINE,
  localparam int CNT_W          = led_cnt_w(BYTES_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [CNT_W-1:0]  i_wr_lane,
  input  logic [BYTE_W-1:0] i_wr_byte,
  input  logic              i_set_full,
  input  logic [IDX_W-1:0]  i_set_idx,
  input  logic              i_clr_full,
  output logic [LINE_W-1:0] o_data,
  output logic              o_full,
  output logic [IDX_W-1:0]  o_idx
);

  logic [LINE_W-1:0] r_data;
  logic              r_full;
  logic [IDX_W-1:0]  r_idx;

  // Byte lane k lands at the top of the word first: lane 0 is the MSB byte.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < BYTES_PER_LINE; k++) begin
        if (i_wr_lane == CNT_W'(k)) begin
          r_data[LINE_W-1-BYTE_W*k -: BYTE_W] <= i_wr_byte;
        end
      end
    end
  end

  // Full flag: set on line completion, cleared when the consumer takes the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end
  end

  // Line index is captured together with the full flag and held until reuse.
  always_ff @(posedge clk) begin
    if (i_set_full) begin
      r_idx <= i_set_idx;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;
  assign o_idx  = r_idx;

endmodule

// File: rtl/led_line_packer.sv
// Packs a byte stream into full-line words through a two-bank ping-pong buffer
// and presents each line with its frame position to the SPI controller.
import led_pkg::*;

module led_line_packer #(
  parameter int  BYTE_W          = LED_BYTE_W,
  parameter int  BYTES_PER_LINE  = LED_BYTES_PER_LINE,
  parameter int  LINES_PER_FRAME = LED_LINES_PER_FRAME,
  localparam int LINE_W          = BYTE_W * BYTES_PER_LINE,
  localparam int IDX_W           = led_cnt_w(LINES_PER_FRAME)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic [LINE_W-1:0] line_data,
  output logic              line_valid,
  input  logic              line_ack,
  output logic [IDX_W-1:0]  line_idx,
  output logic              line_first,
  output logic              line_last,
  output logic              err_sof
);

  localparam int CNT_W = led_cnt_w(BYTES_PER_LINE);

  logic [CNT_W-1:0] r_byte_cnt;
  logic [IDX_W-1:0] r_wr_line;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_err_sof;

  logic [LINE_W-1:0] w_bank_data [2];
  logic [IDX_W-1:0]  w_bank_idx  [2];
  logic [1:0]        w_bank_full;

  logic             w_take;
  logic             w_sof;
  logic [CNT_W-1:0] w_lane;
  logic [IDX_W-1:0] w_line_cur;
  logic [IDX_W-1:0] w_line_next;
  logic             w_line_done;
  logic             w_ack;

  // A start-of-frame beat restarts the line at lane 0 and the frame at line 0.
  assign w_take      = s_valid & s_ready;
  assign w_sof       = w_take & s_sof;
  assign w_lane      = w_sof ? '0 : r_byte_cnt;
  assign w_line_cur  = w_sof ? '0 : r_wr_line;
  assign w_line_next = (w_line_cur == IDX_W'(LINES_PER_FRAME-1)) ? '0 : w_line_cur + 1'b1;
  assign w_line_done = w_take & (w_lane == CNT_W'(BYTES_PER_LINE-1));
  assign w_ack       = line_valid & line_ack;

  // The write and read banks only coincide when both are empty or both full,
  // so a completion and an ack on the same edge always hit different banks.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    led_line_bank #(
      .BYTE_W         (BYTE_W),
      .BYTES_PER_LINE (BYTES_PER_LINE),
      .IDX_W          (IDX_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_take & (r_wr_bank == 1'(b))),
      .i_wr_lane  (w_lane),
      .i_wr_byte  (s_data),
      .i_set_full (w_line_done & (r_wr_bank == 1'(b))),
      .i_set_idx  (w_line_cur),
      .i_clr_full (w_ack & (r_rd_bank == 1'(b))),
      .o_data     (w_bank_data[b]),
      .o_full     (w_bank_full[b]),
      .o_idx      (w_bank_idx[b])
    );
  end

  // Write side: byte counter, frame line counter, bank steering and SOF error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_wr_line  <= '0;
      r_wr_bank  <= 1'b0;
      r_err_sof  <= 1'b0;
    end else begin
      r_err_sof <= w_sof & (r_byte_cnt != '0);
      if (w_take) begin
        if (w_line_done) begin
          r_byte_cnt <= '0;
          r_wr_line  <= w_line_next;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_byte_cnt <= w_lane + 1'b1;
          r_wr_line  <= w_line_cur;
        end
      end
    end
  end

  // Read side: advance to the other bank each time a line is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
    end else if (w_ack) begin
      r_rd_bank <= ~r_rd_bank;
    end
  end

  // Data and index read as zero while nothing is presented, giving the idle
  // values line_idx=0 / line_first=1 without resetting the storage.
  assign s_ready    = ~w_bank_full[r_wr_bank];
  assign line_valid = w_bank_full[r_rd_bank];
  assign line_data  = line_valid ? w_bank_data[r_rd_bank] : '0;
  assign line_idx   = line_valid ? w_bank_idx[r_rd_bank] : '0;
  assign line_first = (line_idx == '0);
  assign line_last  = (line_idx == IDX_W'(LINES_PER_FRAME-1));
  assign err_sof    = r_err_sof;

endmodule

// File: tb/tb_led_line_packer.sv
// Directed bench for led_line_packer with a queue scoreboard checked on every
// line handshake.
module tb_led_line_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_sof;
  logic         s_ready;
  logic [399:0] line_data;
  logic         line_valid;
  logic         line_ack;
  logic [7:0]   line_idx;
  logic         line_first;
  logic         line_last;
  logic         err_sof;

  always #5 clk = ~clk;

  led_line_packer dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .line_data  (line_data),
    .line_valid (line_valid),
    .line_ack   (line_ack),
    .line_idx   (line_idx),
    .line_first (line_first),
    .line_last  (line_last),
    .err_sof    (err_sof)
  );

  typedef struct packed {
    logic [399:0] data;
    logic [7:0]   idx;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_miss = 0;
  logic [399:0] m_buf;
  int           m_cnt, m_line, m_err_exp, m_err_seen;
  int           n_sent, n_stall, n_popped;

  task automatic check_i(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_d(input string name, input logic [399:0] act, input logic [399:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model of the packing: updated for every beat the DUT takes.
  task automatic model_beat(input logic [7:0] b, input logic sof);
    if (sof) begin
      if (m_cnt != 0) m_err_exp++;
      m_cnt  = 0;
      m_line = 0;
    end
    m_buf[399-8*m_cnt -: 8] = b;
    m_cnt++;
    if (m_cnt == 50) begin
      q.push_back('{data: m_buf, idx: 8'(m_line)});
      m_line = (m_line + 1) % 256;
      m_cnt  = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic sof);
    int  guard;
    bit  taken;
    guard = 0;
    taken = 0;
    s_data  = b;
    s_sof   = sof;
    s_valid = 1'b1;
    while (!taken && guard <= 400) begin
      @(negedge clk);
      if (s_ready) taken = 1;
      else begin
        n_stall++;
        guard++;
      end
    end
    if (taken) begin
      model_beat(b, sof);
      n_sent++;
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: beat %0h not accepted, expected acceptance within 400 cycles", b);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_line(input int base, input bit sof);
    for (int k = 0; k < 50; k++) send(8'(base + k), sof && (k == 0));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    line_ack = 1'b1;
    while ((q.size() != 0 || line_valid) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    line_ack = 1'b0;
    check_i("drain_queue_empty", q.size(), 0);
  endtask

  task automatic clear_model();
    q.delete();
    m_cnt = 0; m_line = 0; m_err_exp = 0; m_err_seen = 0;
    n_sent = 0; n_stall = 0; n_popped = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; line_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Monitor: compare each consumed line against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_sof) m_err_seen++;
      if (line_valid && line_ack) begin
        if (q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_line: got idx %0d, expected no line", line_idx);
        end else begin
          mon_e = q.pop_front();
          n_popped++;
          check_d("line_data", line_data, mon_e.data);
          check_i("line_idx", int'(line_idx), int'(mon_e.idx));
          check_i("line_first", int'(line_first), int'(mon_e.idx == 8'd0));
          check_i("line_last", int'(line_last), int'(mon_e.idx == 8'd255));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; line_ack = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_i("rst_line_valid", int'(line_valid), 0);
    check_i("rst_s_ready", int'(s_ready), 1);
    check_d("rst_line_data", line_data, '0);
    check_i("rst_line_idx", int'(line_idx), 0);
    check_i("rst_line_first", int'(line_first), 1);
    check_i("rst_line_last", int'(line_last), 0);
    check_i("rst_err_sof", int'(err_sof), 0);
    rst = 1'b0;

    // Single line, no ack: appears the cycle after beat 49.
    for (int k = 0; k < 50; k++) begin
      if (k == 49) check_i("t1_valid_before_last", int'(line_valid), 0);
      send(8'(k), k == 0);
    end
    check_i("t1_line_valid", int'(line_valid), 1);
    check_i("t1_first_byte", int'(line_data[399:392]), 'h00);
    check_i("t1_last_byte", int'(line_data[7:0]), 'h31);
    check_i("t1_line_idx", int'(line_idx), 0);
    check_i("t1_line_first", int'(line_first), 1);
    drain();

    // Both banks fill, third line stalls until the first ack.
    do_reset();
    fork
      begin
        for (int i = 0; i < 150; i++) send(8'(i), i == 0);
      end
      begin
        int g;
        g = 0;
        while (n_sent < 100 && g < 1000) begin
          @(negedge clk);
          g++;
        end
        repeat (5) @(negedge clk);
        check_i("t2_s_ready_low", int'(s_ready), 0);
        check_i("t2_stalled_at_100", n_sent, 100);
        check_i("t2_line_valid", int'(line_valid), 1);
        check_i("t2_line_idx", int'(line_idx), 0);
        @(posedge clk); #1;
        line_ack = 1'b1;
      end
    join
    drain();
    check_i("t2_lines_seen", n_popped, 3);

    // Continuous stream with ack held: no stalls, idx wraps 255 -> 0.
    do_reset();
    line_ack = 1'b1;
    for (int l = 0; l < 257; l++) send_line(l * 7, l == 0);
    check_i("t3_no_stall", n_stall, 0);
    drain();
    check_i("t3_lines_seen", n_popped, 257);

    // SOF mid-line drops the partial line and flags it once.
    do_reset();
    line_ack = 1'b1;
    for (int k = 0; k < 20; k++) send(8'('hA0 + k), k == 0);
    send_line('h55, 1'b1);
    send_line('h10, 1'b0);
    drain();
    check_i("t4_err_sof_pulses", m_err_seen, 1);
    check_i("t4_lines_seen", n_popped, 2);

    // Line completion and ack of the previous line on the same edge.
    do_reset();
    send_line('h20, 1'b1);
    for (int k = 0; k < 49; k++) send(8'('h80 + k), 1'b0);
    line_ack = 1'b1;
    send(8'('h80 + 49), 1'b0);
    line_ack = 1'b0;
    check_i("t5_line_valid", int'(line_valid), 1);
    check_i("t5_line_idx", int'(line_idx), 1);
    check_i("t5_first_byte", int'(line_data[399:392]), 'h80);
    check_i("t5_last_byte", int'(line_data[7:0]), 'hB1);
    check_i("t5_queue_left", q.size(), 1);
    drain();

    // Reset while a line is presented and the next one is part-filled.
    do_reset();
    send_line('h30, 1'b1);
    for (int k = 0; k < 30; k++) send(8'('h40 + k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_i("t6_line_valid", int'(line_valid), 0);
    check_i("t6_s_ready", int'(s_ready), 1);
    check_i("t6_line_idx", int'(line_idx), 0);
    rst = 1'b0;
    clear_model();
    send_line('h60, 1'b0);
    check_i("t6_new_valid", int'(line_valid), 1);
    check_i("t6_new_idx", int'(line_idx), 0);
    check_i("t6_new_first_byte", int'(line_data[399:392]), 'h60);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
